nibble_serial_adder: RTL and testbench

Multi-cycle WIDTH-bit adder/subtractor that time-shares a single instance of the existing 4-bit `ripple_carry_adder4` datapath. Operands are accepted over a valid/ready handshake, processed one nibble per cycle (LSB nibble first) with the carry held in a register between cycles, and the result is presented over a second valid/ready handshake. It trades latency for area wherever wide additions are infrequent.

---
 rtl/nibble_serial_adder.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : WIDTH-bit add/subtract computed one nibble per cycle on a
//                single shared 4-bit ripple-carry datapath, valid/ready I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_carry_adder4 (
  input  logic [3:0] i_p,
  input  logic [3:0] i_q,
  input  logic       i_c0,
  output logic [4:0] o_r
);
  always_comb begin
    logic w_c;
    o_r = '0;
    w_c = i_c0;
    for (int k = 0; k < 4; k++) begin
      o_r[k] = i_p[k] ^ i_q[k] ^ w_c;
      w_c    = (i_p[k] & i_q[k]) | (w_c & (i_p[k] ^ i_q[k]));
    end
    o_r[4] = w_c;
  end
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IW-1:0]    r_idx;
  logic [4:0]       w_r;
  logic             w_last;

  // Operands are shifted right so the active nibble always sits at [3:0].
  ripple_carry_adder4 u_rca (
    .i_p  (r_a[3:0]),
    .i_q  (r_b[3:0]),
    .i_c0 (r_carry),
    .o_r  (w_r)
  );

  assign w_last = (r_idx == IW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
      S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub ? 1'b1 : cin;
          r_idx   <= '0;
        end
        S_BUSY: begin
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          // Result nibbles enter from the top, landing in place after NIB steps.
          r_sum   <= {w_r[3:0], r_sum[WIDTH-1:4]};
          r_carry <= w_r[4];
          r_idx   <= r_idx + IW'(1);
          if (w_last) r_cout <= w_r[4];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Directed, table-driven bench for nibble_serial_adder (16 bit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             co;
  } vec_t;

  vec_t vecs[9];
  vec_t b2b[3];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents operands in IDLE; returns just after the accept edge.
  task automatic launch(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic isub, input logic icin);
    @(negedge clk);
    a = ia; b = ib; sub = isub; cin = icin; in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called right after the accept edge; checks exact latency and the result.
  task automatic wait_done(input string name, input logic [WIDTH-1:0] es, input logic ec);
    logic ok = 1'b1;
    for (int k = 1; k <= NIB; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== (k == NIB)) ok = 1'b0;
      if (busy !== 1'b1) ok = 1'b0;
    end
    chk({name, "_latency"}, 32'(ok), 32'd1);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("idle_after_handshake", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'h0FFF, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0};
    vecs[3] = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1};
    vecs[4] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0001, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0};

    b2b[0]  = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0};
    b2b[1]  = '{16'h0010, 16'h0020, 1'b1, 1'b0, 16'hFFF0, 1'b0};
    b2b[2]  = '{16'hF000, 16'h1000, 1'b0, 1'b1, 16'h0001, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
      wait_done($sformatf("vec%0d", i), vecs[i].s, vecs[i].co);
      release_result();
    end

    // Backpressure: result held while new operands wait at the input.
    launch(16'h0100, 16'h0023, 1'b0, 1'b0);
    wait_done("bp_first", 16'h0123, 1'b0);
    a = 16'h0003; b = 16'h0004; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold_flags", {29'd0, in_ready, out_valid, busy}, 32'b011);
      chk("bp_hold_sum", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h0123});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_idle", {30'd0, in_ready, out_valid}, 32'b10);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done("bp_pending", 16'h0007, 1'b0);
    release_result();

    // Reset two cycles into BUSY must abort asynchronously.
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("midrst_sum", {15'd0, cout, sum}, 32'd0);
    repeat (6) @(posedge clk);
    #1 chk("midrst_no_result", 32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done("after_rst", 16'h0100, 1'b0);
    release_result();

    // Back-to-back with both handshakes held high.
    begin
      int acc_cyc[3];
      int n_acc = 0;
      int n_res = 0;
      int idle_gaps = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && n_res < 3; c++) begin
        @(negedge clk);
        if (out_valid) begin
          chk($sformatf("b2b%0d_result", n_res), {15'd0, cout, sum},
              {15'd0, b2b[n_res].co, b2b[n_res].s});
          n_res++;
        end
        if (in_ready && n_acc < 3) begin
          if (n_acc > 0) idle_gaps++;
          a = b2b[n_acc].a; b = b2b[n_acc].b;
          sub = b2b[n_acc].sub; cin = b2b[n_acc].cin; in_valid = 1'b1;
          acc_cyc[n_acc] = c;
          n_acc++;
        end else if (n_acc == 3) begin
          in_valid = 1'b0;
        end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_results_seen", 32'(n_res), 32'd3);
      chk("b2b_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NIB + 2));
      chk("b2b_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(NIB + 2));
      chk("b2b_idle_gaps", 32'(idle_gaps), 32'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
